// File: rtl/mash_sdm_cfg_if.sv
// rtl/mash_sdm_cfg_if.sv - control, fraction and output bundle of the MASH modulator
interface mash_sdm_cfg_if #(
  parameter int W = 16
);
  logic         en;
  logic [1:0]   order;
  logic         dither_on;
  logic [W-1:0] din;
  logic [3:0]   dout;
  logic         dout_vld;
  logic         carry_last;

  modport master (
    output en, order, dither_on, din,
    input  dout, dout_vld, carry_last
  );

  modport slave (
    input  en, order, dither_on, din,
    output dout, dout_vld, carry_last
  );
endinterface

// File: rtl/mash_sdm_cfg.sv
// rtl/mash_sdm_cfg.sv - MASH 1/2/3 sigma-delta modulator with sample gating and LFSR dither
module mash_sdm_cfg #(
  parameter int          W         = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rstn,
  mash_sdm_cfg_if.slave bus
);

  // An all-zero seed would lock the LFSR, so it is swapped for 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  logic [W-1:0] acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic         c2d1_q, c2d1_d, c3d1_q, c3d1_d, c3d2_q, c3d2_d;
  logic [1:0]   order_q, order_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [3:0]   dout_q, dout_d;
  logic         dout_vld_q, dout_vld_d;
  logic         carry_last_q, carry_last_d;

  logic [1:0]   ord_eff;
  logic         st2, st3, dith_bit;
  logic [W:0]   s1, s2, s3;
  logic         c1, c2, c3, c_last;
  logic [W-1:0] r1, r2;
  logic [3:0]   y;
  logic [15:0]  lfsr_next;

  // Stage chain, noise-shaping combiner and next-state selection.
  always_comb begin
    ord_eff   = (order_q == 2'd0) ? 2'd1 : order_q;
    st2       = ord_eff[1];
    st3       = (ord_eff == 2'd3);
    dith_bit  = bus.dither_on & lfsr_q[0];

    s1 = {1'b0, acc1_q} + {1'b0, bus.din} + {{W{1'b0}}, dith_bit};
    c1 = s1[W];
    r1 = s1[W-1:0];
    s2 = {1'b0, acc2_q} + {1'b0, r1};
    c2 = st2 & s2[W];
    r2 = s2[W-1:0];
    s3 = {1'b0, acc3_q} + {1'b0, r2};
    c3 = st3 & s3[W];

    // Inactive stages contribute zero carries, and their delay regs stay zero,
    // so the order-3 formula collapses to the lower orders automatically.
    y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2d1_q}
      + {3'b000, c3} - {2'b00, c3d1_q, 1'b0} + {3'b000, c3d2_q};

    c_last    = st3 ? c3 : (st2 ? c2 : c1);
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    acc1_d       = acc1_q;
    acc2_d       = acc2_q;
    acc3_d       = acc3_q;
    c2d1_d       = c2d1_q;
    c3d1_d       = c3d1_q;
    c3d2_d       = c3d2_q;
    order_d      = bus.order;
    lfsr_d       = lfsr_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    carry_last_d = carry_last_q;

    if (bus.order != order_q) begin
      // A new order starts from a clean state; the dither sequence carries on.
      acc1_d = '0;
      acc2_d = '0;
      acc3_d = '0;
      c2d1_d = 1'b0;
      c3d1_d = 1'b0;
      c3d2_d = 1'b0;
      dout_d = 4'd0;
    end else if (bus.en) begin
      acc1_d       = r1;
      acc2_d       = st2 ? r2 : '0;
      acc3_d       = st3 ? s3[W-1:0] : '0;
      c2d1_d       = c2;
      c3d1_d       = c3;
      c3d2_d       = c3d1_q;
      lfsr_d       = lfsr_next;
      dout_d       = y;
      dout_vld_d   = 1'b1;
      carry_last_d = c_last;
    end
  end

  // State register with synchronous active-high reset on rstn.
  always_ff @(posedge clk) begin
    if (rstn) begin
      acc1_q       <= '0;
      acc2_q       <= '0;
      acc3_q       <= '0;
      c2d1_q       <= 1'b0;
      c3d1_q       <= 1'b0;
      c3d2_q       <= 1'b0;
      order_q      <= bus.order;
      lfsr_q       <= SEED_EFF;
      dout_q       <= 4'd0;
      dout_vld_q   <= 1'b0;
      carry_last_q <= 1'b0;
    end else begin
      acc1_q       <= acc1_d;
      acc2_q       <= acc2_d;
      acc3_q       <= acc3_d;
      c2d1_q       <= c2d1_d;
      c3d1_q       <= c3d1_d;
      c3d2_q       <= c3d2_d;
      order_q      <= order_d;
      lfsr_q       <= lfsr_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      carry_last_q <= carry_last_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.carry_last = carry_last_q;

endmodule
